// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline-stage definitions: occupancy encodings and default payload geometry
// used by every inter-stage buffer instance.
package pipe_stage_buf_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CHANNELS = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones until reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, 2-entry skid buffer, flush
// with optional payload zeroing, occupancy output and saturating stall counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int DW = CHANNELS * WIDTH;

  occ_e          r_state;
  occ_e          w_state_nxt;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          w_accept;
  logic          w_pop;
  logic          w_load_main;
  logic          w_load_skid;
  logic          w_shift;
  logic          w_stall;

  // Readiness depends only on held state, so out_ready never reaches in_ready.
  assign in_ready  = (r_state != OCC_TWO) & ~flush & ~reset;
  assign out_valid = (r_state != OCC_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_stall   = out_valid & ~out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = OCC_ONE;
          w_load_main = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_pop) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (w_pop) begin
          w_state_nxt = OCC_ONE;
          w_shift     = 1'b1;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_shift     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: payload registers are reset because a zero instruction word downstream is a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush && (FLUSH_ZERO != 0)) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= in_data;
      end else if (w_shift) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign out_data  = r_main;
  assign occupancy = r_state;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: three buffer variants share one stimulus stream and are
// compared against a queue-based FIFO model after every clock edge.
module tb_pipe_stage_buf;

  localparam int W  = 16;
  localparam int C  = 3;
  localparam int DW = W * C;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [3:0]    c_stall;

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .FLUSH_ZERO(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .FLUSH_ZERO(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall));

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .FLUSH_ZERO(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_stall));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entries held, last head value seen per flush policy, stall counts.
  logic [DW-1:0] q[$];
  logic [DW-1:0] hold_z;
  logic [DW-1:0] hold_nz;
  int unsigned   st16;
  int unsigned   st4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold_z  = '0;
    hold_nz = '0;
    st16    = 0;
    st4     = 0;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ez;
    logic [DW-1:0] enz;
    ez  = (q.size() != 0) ? q[0] : hold_z;
    enz = (q.size() != 0) ? q[0] : hold_nz;
    check("out_valid",      64'(a_out_valid), 64'(q.size() != 0));
    check("out_valid_nz",   64'(b_out_valid), 64'(q.size() != 0));
    check("occupancy",      64'(a_occ),       64'(q.size()));
    check("occupancy_nz",   64'(b_occ),       64'(q.size()));
    check("out_data_zero",  64'(a_out_data),  64'(ez));
    check("out_data_keep",  64'(b_out_data),  64'(enz));
    check("out_data_cnt4",  64'(c_out_data),  64'(ez));
    check("stall_cnt16",    64'(a_stall),     64'(st16));
    check("stall_cnt4",     64'(c_stall),     64'(st4));
  endtask

  // One clock cycle: drive inputs, check in_ready before the edge, advance model, check outputs.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic exp_rdy;
    logic acc;
    logic pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #3;
    exp_rdy = (q.size() < 2) && !f && !reset;
    check("in_ready",    64'(a_in_ready), 64'(exp_rdy));
    check("in_ready_nz", 64'(b_in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    pop = (q.size() != 0) && r;
    @(posedge clk);
    if ((q.size() != 0) && !r) begin
      if (st16 < 65535) st16++;
      if (st4 < 15) st4++;
    end
    if (f) begin
      q.delete();
      hold_z = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    if (q.size() != 0) begin
      hold_z  = q[0];
      hold_nz = q[0];
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), 16'($urandom())};
  endfunction

  initial begin
    logic [DW-1:0] a_w, b_w;

    // Power-on reset
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    #1;
    check_outputs();
    check("in_ready_rst", 64'(a_in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming: channel0 carries 1..100 at full rate
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, {32'($urandom()), 16'(i)}, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: A then B held, extra offers rejected, then drain in order
    a_w = rnd_word();
    b_w = rnd_word();
    step(1'b1, a_w, 1'b0, 1'b0);
    step(1'b1, b_w, 1'b0, 1'b0);
    check("bp_head_is_A", 64'(a_out_data), 64'(a_w));
    repeat (3) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_then_B", 64'(a_out_data), 64'(b_w));
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush at occupancy 2 with a same-cycle offer
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Saturation of the 4-bit counter, then flush leaves it saturated
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0);
    check("sat_at_15", 64'(c_stall), 64'(15));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Simultaneous accept and pop at occupancy 1
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    a_w = rnd_word();
    step(1'b1, a_w, 1'b1, 1'b0);
    check("simul_new_head", 64'(a_out_data), 64'(a_w));

    // Asynchronous reset mid-stream at occupancy 2
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("in_ready_async_rst", 64'(a_in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_w = rnd_word();
    step(1'b1, a_w, 1'b1, 1'b0);
    check("first_after_rst", 64'(a_out_data), 64'(a_w));

    // Random traffic against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_word(),
           1'($urandom_range(0, 3) != 0 || i < 3000 ? $urandom_range(0, 1) : 1),
           1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
